// File: rtl/spi_cmd_bridge.sv
// SPI command bridge: decodes a 4-byte SPI frame at end of transfer
// and runs one read or write on the system memory bus.
module spi_cmd_bridge #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic [7:0]  rx0,
  input  logic [7:0]  rx1,
  input  logic [7:0]  rx2,
  input  logic [7:0]  rx3,
  output logic        bus_req,
  output logic        bus_rw_n,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        cs_s1_q, cs_s1_d;
  logic        cs_s2_q, cs_s2_d;
  logic        cs_s3_q, cs_s3_d;
  logic        eot_q, eot_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_n_q, rw_n_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        req_q, req_d;
  logic [7:0]  rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  timer_q, timer_d;

  logic unused_rx;
  assign unused_rx = ^rx0[4:0];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cs_s1_q <= 1'b1;
      cs_s2_q <= 1'b1;
      cs_s3_q <= 1'b1;
      eot_q   <= 1'b0;
      addr_q  <= '0;
      rw_n_q  <= 1'b1;
      wdata_q <= '0;
      req_q   <= 1'b0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cs_s1_q <= cs_s1_d;
      cs_s2_q <= cs_s2_d;
      cs_s3_q <= cs_s3_d;
      eot_q   <= eot_d;
      addr_q  <= addr_d;
      rw_n_q  <= rw_n_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cs_s1_d = spi_cs_n;
    cs_s2_d = cs_s1_q;
    cs_s3_d = cs_s2_q;
    eot_d   = cs_s2_q & ~cs_s3_q;
    addr_d  = addr_q;
    rw_n_d  = rw_n_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    err_d   = err_q;
    timer_d = timer_q;

    // a frame arriving anywhere but IDLE is an overrun
    if (eot_q) begin
      if (state_q == IDLE) begin
        busy_d  = 1'b1;
        rw_n_d  = ~rx0[6];
        addr_d  = rx0[7] ? addr_q + 16'd1
                         : {rx1, rx2};
        if (rx0[6]) wdata_d = rx3;
        if (rx0[5]) err_d = 1'b0;
        state_d = REQ;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: ;
      REQ: begin
        req_d   = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          if (rw_n_q) rd_d = bus_rdata;
          state_d = DONE;
        end else if (timer_q == TO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_req   = req_q;
  assign bus_rw_n  = rw_n_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign rd_data   = rd_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Bench for spi_cmd_bridge: transaction-level model, bus responder
// and per-cycle compare all driven from one sequencing process.
module tb_spi_cmd_bridge;

  localparam int TO = 15;

  logic        clk_sys;
  logic        reset;
  logic        spi_cs_n;
  logic [7:0]  rx0, rx1, rx2, rx3;
  logic        bus_req, bus_rw_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_ack;
  logic [7:0]  rd_data;
  logic        busy, err;

  spi_cmd_bridge #(.ACK_TIMEOUT(TO)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .spi_cs_n (spi_cs_n),
    .rx0      (rx0),
    .rx1      (rx1),
    .rx2      (rx2),
    .rx3      (rx3),
    .bus_req  (bus_req),
    .bus_rw_n (bus_rw_n),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack),
    .rd_data  (rd_data),
    .busy     (busy),
    .err      (err)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  int n_pass  = 0;
  int n_total = 0;

  // model state
  logic [15:0] m_addr = 0;
  logic        m_err  = 0;
  logic [7:0]  m_rd   = 0;
  logic [15:0] exp_addr = 0;
  logic        exp_rw = 1;
  logic [7:0]  exp_wdata = 0;

  // responder and observation state
  bit   resp_active = 0;
  int   resp_cnt = 0;
  int   resp_delay = 0;
  logic [7:0] resp_data = 0;
  bit   req_prev = 0;
  bit   busy_prev = 0;
  int   txn_cnt = 0;
  int   req_len = 0;
  int   last_len = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk_sys);
    bus_ack = 1'b0;
    if (bus_req) begin
      if (!req_prev) begin
        txn_cnt++;
        req_len = 0;
      end
      req_len++;
      chk("bus_addr", bus_addr, exp_addr);
      chk("bus_rw_n", bus_rw_n, exp_rw);
      if (!exp_rw) chk("bus_wdata", bus_wdata, exp_wdata);
    end else if (req_prev) begin
      last_len = req_len;
    end
    if (busy_prev && !busy) begin
      chk("rd_data", rd_data, m_rd);
      chk("err", err, m_err);
    end
    req_prev  = bus_req;
    busy_prev = busy;
    if (resp_active && bus_req) begin
      if (resp_cnt == resp_delay) begin
        bus_ack     = 1'b1;
        bus_rdata   = resp_data;
        resp_active = 0;
      end else begin
        resp_cnt++;
      end
    end
  endtask

  task automatic pulse(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    spi_cs_n = 1'b0;
    rx0 = b0;
    rx1 = b1;
    rx2 = b2;
    rx3 = b3;
    tick();
    tick();
    spi_cs_n = 1'b1;
  endtask

  // update model from command rules, then launch the frame
  task automatic start_cmd(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input int dly, input logic [7:0] rdat);
    int k;
    logic [1:0] op;
    op = b0[7:6];
    if (b0[5]) m_err = 0;
    case (op)
      2'b00: m_addr = {b1, b2};
      2'b01: m_addr = {b1, b2};
      default: m_addr = m_addr + 16'd1;
    endcase
    exp_addr = m_addr;
    exp_rw   = (op == 2'b00 || op == 2'b10);
    if (!exp_rw) exp_wdata = b3;
    if (dly < TO) begin
      if (exp_rw) m_rd = rdat;
    end else begin
      m_err = 1;
    end
    resp_active = 1;
    resp_cnt    = 0;
    resp_delay  = dly;
    resp_data   = rdat;
    pulse(b0, b1, b2, b3);
    k = 0;
    while (!bus_req && k < 20) begin
      tick();
      k++;
    end
    chk("cs_to_req", k, 5);
  endtask

  task automatic finish_cmd();
    int n;
    n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    chk("busy_fall", busy, 0);
  endtask

  task automatic do_cmd(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input int dly, input logic [7:0] rdat);
    start_cmd(b0, b1, b2, b3, dly, rdat);
    finish_cmd();
  endtask

  initial begin
    int base;
    logic [7:0] r3a, r3b;
    reset = 1'b1;
    spi_cs_n = 1'b1;
    rx0 = 0; rx1 = 0; rx2 = 0; rx3 = 0;
    bus_ack = 1'b0;
    bus_rdata = 0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("rst_req", bus_req, 0);
    chk("rst_rw_n", bus_rw_n, 1);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    // 1: read 1234, ack after 2 WAIT cycles
    do_cmd(8'h00, 8'h12, 8'h34, 8'h99, 2, 8'hA5);
    chk("t1_rd", rd_data, 8'hA5);
    chk("t1_addr", bus_addr, 16'h1234);
    chk("t1_rw", bus_rw_n, 1);
    chk("t1_err", err, 0);

    // 2: write then write-next
    do_cmd(8'h40, 8'hC0, 8'h00, 8'h5A, 1, 8'h00);
    do_cmd(8'hC0, 8'h77, 8'h66, 8'h5B, 0, 8'h00);
    chk("t2_addr", bus_addr, 16'hC001);
    chk("t2_wdata", bus_wdata, 8'h5B);
    chk("t2_rw", bus_rw_n, 0);
    chk("t2_rd", rd_data, 8'hA5);

    // 3: read FFFF then read-next wraps
    r3a = 8'($urandom);
    r3b = 8'($urandom);
    do_cmd(8'h00, 8'hFF, 8'hFF, 8'h00, 4, r3a);
    do_cmd(8'h80, 8'h12, 8'h12, 8'h00, 3, r3b);
    chk("t3_wrap", bus_addr, 16'h0000);
    chk("t3_rd", rd_data, r3b);

    // 4: no ack, then CLR with read at 0000
    do_cmd(8'h00, 8'h22, 8'h22, 8'h00, 40, 8'h11);
    chk("t4_len", last_len, TO);
    chk("t4_err", err, 1);
    chk("t4_rd", rd_data, r3b);
    do_cmd(8'h20, 8'h00, 8'h00, 8'h00, 3, 8'h3C);
    chk("t4_clr", err, 0);
    chk("t4_rd2", rd_data, 8'h3C);

    // 5: overrun during a stalled WAIT
    base = txn_cnt;
    start_cmd(8'h00, 8'h42, 8'h42, 8'h00, 12, 8'hE1);
    pulse(8'h00, 8'hBE, 8'hEF, 8'h00);
    m_err = 1;
    finish_cmd();
    chk("t5_txns", txn_cnt - base, 1);
    chk("t5_err", err, 1);
    chk("t5_addr", bus_addr, 16'h4242);
    do_cmd(8'h80, 8'h00, 8'h00, 8'h00, 1, 8'h0F);
    chk("t5_next", bus_addr, 16'h4243);

    // randomized commands, including timeouts
    for (int i = 0; i < 24; i++) begin
      do_cmd(8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), $urandom_range(0, 20),
             8'($urandom));
    end

    // 6: reset during WAIT, stray ack afterwards
    start_cmd(8'h00, 8'h11, 8'h11, 8'h00, 40, 8'h00);
    repeat (3) tick();
    reset = 1'b1;
    m_addr = 0;
    m_err = 0;
    m_rd = 0;
    resp_active = 0;
    tick();
    reset = 1'b0;
    chk("t6_req", bus_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rd", rd_data, 0);
    chk("t6_err", err, 0);
    bus_rdata = 8'hDD;
    bus_ack = 1'b1;
    repeat (4) tick();
    chk("t6_req2", bus_req, 0);
    chk("t6_busy2", busy, 0);
    chk("t6_rd2", rd_data, 0);
    do_cmd(8'h80, 8'h55, 8'h55, 8'h00, 2, 8'h6E);
    chk("t6_addr", bus_addr, 16'h0001);
    chk("t6_rd3", rd_data, 8'h6E);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
